hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core; next generation of the single-cycle stall/flush unit.
//  Detects load-use hazards in ID and holds the front end for a configurable load latency.
//  Freezes the pipeline while data memory is busy and issues a multi-stage flush vector on taken branches.
//  Defers a flush that arrives during a memory freeze. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_ADDR_W   5   register-file address width
//  LOAD_LAT     1   front-end stall cycles per load-use hazard (>=1)
//  FLUSH_DEPTH  2   pipeline registers cleared on a taken branch; bit0=IF/ID, bit1=ID/EX, ...
//  CNT_W        16  width of the stall_cycles performance counter
// PORTS
//  clk           in   1            rising-edge clock
//  rst           in   1            synchronous, active-high reset
//  id_rs1        in   REG_ADDR_W   rs1 of the instruction in ID
//  id_rs2        in   REG_ADDR_W   rs2 of the instruction in ID
//  id_uses_rs1   in   1            ID instruction reads rs1
//  id_uses_rs2   in   1            ID instruction reads rs2
//  ex_rd         in   REG_ADDR_W   destination register of the instruction in EX
//  ex_memread    in   1            instruction in EX is a load
//  branch_taken  in   1            branch or jump resolved taken this cycle
//  mem_busy      in   1            data memory not ready; whole pipeline must hold
//  pc_en         out  1            PC write enable
//  if_id_en      out  1            IF/ID write enable
//  id_ex_bubble  out  1            insert a NOP into ID/EX
//  freeze        out  1            hold every pipeline register
//  stall         out  1            summary: pc_en==0
//  flush_vec     out  FLUSH_DEPTH  per-stage flush strobes
//  stall_cycles  out  CNT_W        saturating count of cycles with stall=1
// BEHAVIOUR
//  Load-use detect (combinational): lu = ex_memread & (ex_rd!=0) &
//    ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//  FSM states: IDLE, LU_STALL, FLUSH_PEND. Down-counter lu_cnt is $clog2(LOAD_LAT+1) bits wide.
//  IDLE:
//    - lu=1 and mem_busy=0: stall this cycle (0 latency).
//      If LOAD_LAT>1, load lu_cnt=LOAD_LAT-1 and go to LU_STALL; otherwise stay in IDLE.
//    - branch_taken=1 and mem_busy=1: set pending, go to FLUSH_PEND; no flush this cycle.
//  LU_STALL: stall each cycle; decrement lu_cnt when mem_busy=0; go to IDLE on the cycle lu_cnt==1 decrements.
//  FLUSH_PEND: freeze while mem_busy=1. On the first cycle mem_busy=0, flush_vec=all ones, then go to IDLE.
//  Priority, highest first:
//    1. rst
//    2. mem_busy: freeze=1, pc_en=if_id_en=0, id_ex_bubble=0, flush_vec=0; state and lu_cnt hold.
//    3. branch_taken with mem_busy=0: flush_vec=all ones for exactly that cycle, pc_en=1.
//       Any load-use stall is cancelled; lu_cnt is cleared and the FSM goes to IDLE.
//    4. load-use stall: pc_en=if_id_en=0, id_ex_bubble=1.
//  Simultaneous lu and branch_taken with mem_busy=0: the flush wins; no bubble and no stall.
//  A branch_taken arriving in FLUSH_PEND while mem_busy=1 merges into the single pending flush.
//  stall = ~pc_en. stall_cycles increments on every cycle with stall=1 and saturates at 2^CNT_W-1.
//  Reset (synchronous): state=IDLE, lu_cnt=0, pending=0, stall_cycles=0.
//    While rst=1: pc_en=if_id_en=1, stall=0, id_ex_bubble=0, freeze=0, flush_vec=0.
//    Reset mid-stall or mid-pending discards the stall or flush entirely.
//  ex_rd==0 never causes a stall.
// TESTING
//  LOAD_LAT=1: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle
//    -> stall=1, id_ex_bubble=1 for exactly 1 cycle; stall_cycles=1.
//  LOAD_LAT=3: same hazard -> stall=1 for 3 consecutive cycles; id_ex_bubble=1 each cycle; back to IDLE.
//  LOAD_LAT=3: mem_busy=1 for 2 cycles in the middle of the stall -> freeze=1 on those cycles, bubble=0;
//    total stall window is 5 cycles.
//  FLUSH_DEPTH=3: branch_taken=1 while mem_busy=1 for 4 cycles
//    -> flush_vec=3'b000 during the freeze, 3'b111 on the 5th cycle only.
//  lu and branch_taken in the same cycle -> flush_vec=all ones, stall=0, id_ex_bubble=0.
//  ex_rd=0 hazard -> no stall. CNT_W=4 with 20 stall cycles -> stall_cycles=15.
//  rst asserted in LU_STALL -> next cycle stall=0, stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, memory-busy freeze, branch flush with deferral
// while memory is busy, and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [REG_ADDR_W-1:0]  id_rs1_i,
   input  logic [REG_ADDR_W-1:0]  id_rs2_i,
   input  logic                   id_uses_rs1_i,
   input  logic                   id_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0]  ex_rd_i,
   input  logic                   ex_memread_i,
   input  logic                   branch_taken_i,
   input  logic                   mem_busy_i,
   output logic                   pc_en_o,
   output logic                   if_id_en_o,
   output logic                   id_ex_bubble_o,
   output logic                   freeze_o,
   output logic                   stall_o,
   output logic [FLUSH_DEPTH-1:0] flush_vec_o,
   output logic [CNT_W-1:0]       stall_cycles_o
);

   localparam int unsigned LuCntW = $clog2(LOAD_LAT + 1);
   localparam logic [LuCntW-1:0] LuReload = LuCntW'(LOAD_LAT - 1);
   localparam logic [LuCntW-1:0] LuOne    = LuCntW'(1);

   typedef enum logic [1:0] {StIdle, StLuStall, StFlushPend} state_e;

   state_e            state_q, state_d;
   logic [LuCntW-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic                   lu;
   logic                   pc_en;
   logic                   if_id_en;
   logic                   bubble;
   logic                   freeze;
   logic [FLUSH_DEPTH-1:0] flush_vec;

   assign lu = ex_memread_i && (ex_rd_i != '0) &&
               ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

   always_comb begin
      state_d   = state_q;
      lu_cnt_d  = lu_cnt_q;
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      bubble    = 1'b0;
      freeze    = 1'b0;
      flush_vec = '0;

      if (mem_busy_i) begin
         freeze   = 1'b1;
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         // A branch resolved during a freeze must not be lost; it cancels any load-use stall.
         if (branch_taken_i) begin
            state_d  = StFlushPend;
            lu_cnt_d = '0;
         end
      end else if (branch_taken_i || (state_q == StFlushPend)) begin
         flush_vec = '1;
         state_d   = StIdle;
         lu_cnt_d  = '0;
      end else if (state_q == StLuStall) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         bubble   = 1'b1;
         lu_cnt_d = lu_cnt_q - LuOne;
         if (lu_cnt_q == LuOne) begin
            state_d = StIdle;
         end
      end else if (lu) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         bubble   = 1'b1;
         if (LOAD_LAT > 1) begin
            lu_cnt_d = LuReload;
            state_d  = StLuStall;
         end
      end

      if (rst_i) begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         bubble    = 1'b0;
         freeze    = 1'b0;
         flush_vec = '0;
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         lu_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pc_en_o        = pc_en;
   assign if_id_en_o     = if_id_en;
   assign id_ex_bubble_o = bubble;
   assign freeze_o       = freeze;
   assign stall_o        = ~pc_en;
   assign flush_vec_o    = flush_vec;
   assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations share stimulus and are compared each cycle
// against an abstract model tracking remaining stall cycles, a pending-flush flag and a count.
module tb_hazard_ctrl_unit;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_memread, branch_taken, mem_busy;

   logic       a_pc_en, a_if_id_en, a_bubble, a_freeze, a_stall;
   logic [1:0] a_flush;
   logic [15:0] a_cnt;
   logic       b_pc_en, b_if_id_en, b_bubble, b_freeze, b_stall;
   logic [2:0] b_flush;
   logic [3:0] b_cnt;

   int n_checks = 0;
   int n_errors = 0;

   int lat[2]  = '{1, 3};
   int fd[2]   = '{2, 3};
   int cmax[2] = '{65535, 15};
   int rem[2]  = '{0, 0};
   bit pend[2] = '{0, 0};
   int cnt[2]  = '{0, 0};

   hazard_ctrl_unit #(
      .REG_ADDR_W (5),
      .LOAD_LAT   (1),
      .FLUSH_DEPTH(2),
      .CNT_W      (16)
   ) u_dut_a (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .ex_rd_i       (ex_rd),
      .ex_memread_i  (ex_memread),
      .branch_taken_i(branch_taken),
      .mem_busy_i    (mem_busy),
      .pc_en_o       (a_pc_en),
      .if_id_en_o    (a_if_id_en),
      .id_ex_bubble_o(a_bubble),
      .freeze_o      (a_freeze),
      .stall_o       (a_stall),
      .flush_vec_o   (a_flush),
      .stall_cycles_o(a_cnt)
   );

   hazard_ctrl_unit #(
      .REG_ADDR_W (5),
      .LOAD_LAT   (3),
      .FLUSH_DEPTH(3),
      .CNT_W      (4)
   ) u_dut_b (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .ex_rd_i       (ex_rd),
      .ex_memread_i  (ex_memread),
      .branch_taken_i(branch_taken),
      .mem_busy_i    (mem_busy),
      .pc_en_o       (b_pc_en),
      .if_id_en_o    (b_if_id_en),
      .id_ex_bubble_o(b_bubble),
      .freeze_o      (b_freeze),
      .stall_o       (b_stall),
      .flush_vec_o   (b_flush),
      .stall_cycles_o(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare both DUTs against the model, advance the model.
   task automatic step(input bit r, input bit br, input bit busy, input bit mr, input bit u1,
                       input bit u2, input int rd, input int rs1, input int rs2);
      bit lu, pc, bub, frz, fl;
      int exp_fv;
      string p;
      @(negedge clk);
      rst          = r;
      branch_taken = br;
      mem_busy     = busy;
      ex_memread   = mr;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      ex_rd        = rd[4:0];
      id_rs1       = rs1[4:0];
      id_rs2       = rs2[4:0];
      #1;
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      for (int k = 0; k < 2; k++) begin
         pc = 1'b1; bub = 1'b0; frz = 1'b0; fl = 1'b0;
         if (r) begin
            rem[k] = 0; pend[k] = 1'b0;
         end else if (busy) begin
            pc = 1'b0; frz = 1'b1;
            if (br) begin pend[k] = 1'b1; rem[k] = 0; end
         end else if (br || pend[k]) begin
            fl = 1'b1; pend[k] = 1'b0; rem[k] = 0;
         end else if (rem[k] > 0) begin
            pc = 1'b0; bub = 1'b1; rem[k]--;
         end else if (lu) begin
            pc = 1'b0; bub = 1'b1; rem[k] = lat[k] - 1;
         end
         exp_fv = fl ? ((1 << fd[k]) - 1) : 0;
         p = (k == 0) ? "a" : "b";
         check_eq({p, ".pc_en"},    (k == 0) ? a_pc_en    : b_pc_en,    pc);
         check_eq({p, ".if_id_en"}, (k == 0) ? a_if_id_en : b_if_id_en, pc);
         check_eq({p, ".bubble"},   (k == 0) ? a_bubble   : b_bubble,   bub);
         check_eq({p, ".freeze"},   (k == 0) ? a_freeze   : b_freeze,   frz);
         check_eq({p, ".stall"},    (k == 0) ? a_stall    : b_stall,    !pc);
         check_eq({p, ".flush_vec"}, (k == 0) ? 32'(a_flush) : 32'(b_flush), exp_fv);
         check_eq({p, ".stall_cycles"}, (k == 0) ? 32'(a_cnt) : 32'(b_cnt), cnt[k]);
         if (r) cnt[k] = 0;
         else if (!pc && cnt[k] < cmax[k]) cnt[k]++;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic hazard();
      step(0, 0, 0, 1, 1, 0, 5, 5, 0);
   endtask

   initial begin
      rst = 1'b1; branch_taken = 1'b0; mem_busy = 1'b0; ex_memread = 1'b0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 0, 5, 5, 0);

      // Single load-use hazard: 1 stall cycle for LOAD_LAT=1, 3 for LOAD_LAT=3.
      hazard();
      repeat (3) idle();
      @(posedge clk); #1;
      check_eq("lu1_count", 32'(a_cnt), 1);
      check_eq("lu3_count", 32'(b_cnt), 3);

      // Memory busy for two cycles in the middle of the stall.
      hazard();
      idle();
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      repeat (3) idle();
      @(posedge clk); #1;
      check_eq("lu3_busy_window", 32'(b_cnt), 8);

      // Branch during a 4-cycle freeze, flush released on the 5th cycle.
      repeat (4) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle();
      idle();

      // Load-use and branch together: flush wins. Then an ex_rd=0 hazard.
      step(0, 1, 0, 1, 1, 1, 5, 5, 5);
      idle();
      step(0, 0, 0, 1, 1, 1, 0, 0, 0);
      idle();

      // Counter saturation.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (20) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_eq("sat_a", 32'(a_cnt), 20);
      check_eq("sat_b", 32'(b_cnt), 15);

      // Reset in the middle of a load-use stall.
      hazard();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      idle();

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
